calc_engine: RTL and testbench
==============================

// Module: calc_engine
// PURPOSE
//  Next-generation sequential calculator core for the DE10-Lite top level. It
//  holds the operating MODE, which a debounced key steps through. Operands X and
//  Y are WIDTH bits wide. Each operation is launched by a START pulse and runs as
//  a registered FSM: single-cycle add/sub/logic/compare, multi-cycle shift-add
//  multiply and restoring divide. The top level sends RESULT and the flags to the
//  7-seg/LED muxes; it drives MODE/OPERATION displays from the MODE and OPERATION ports.
// PARAMETERS
//  WIDTH            4      operand width in bits (2..16); RESULT is 2*WIDTH
//  DEBOUNCE_CYCLES  50000  cycles KEY_MODE must be stable before accepted (1 ms @ 50 MHz)
// PORTS
//  CLK        in   1        system clock, all logic on rising edge
//  RST_N      in   1        asynchronous, active-low reset
//  KEY_MODE   in   1        raw push-button, active-low (pressed = 0), asynchronous
//  X          in   WIDTH    operand X
//  Y          in   WIDTH    operand Y
//  OPERATION  in   2        operation select within MODE
//  START      in   1        launch request, sampled only in IDLE
//  MODE       out  2        current mode: 0 arith, 1 logical, 2 compare, 3 reserved
//  BUSY       out  1        high while an operation is in flight (CALC state)
//  DONE       out  1        one-cycle pulse, RESULT/flags valid from this cycle
//  RESULT     out  2*WIDTH  last result, held until next DONE
//  OVERFLOW   out  1        signed overflow of add/sub; 0 for other ops
//  DIV_ZERO   out  1        divide with Y==0
// BEHAVIOUR
//  Reset: MODE=0, BUSY=0, DONE=0, RESULT=0, OVERFLOW=0, DIV_ZERO=0, FSM=IDLE, debouncer cleared.
//  Mode key:
//   - KEY_MODE double-flop synchronised.
//   - Debounced level changes only after DEBOUNCE_CYCLES identical consecutive samples.
//   - Each debounced 1->0 edge increments MODE mod 4 (3 -> 0).
//   - MODE may change while BUSY; the in-flight op uses its latched mode.
//  FSM IDLE -> CALC -> FIN -> IDLE:
//   - IDLE: START=1 latches X, Y, MODE, OPERATION into internal regs; go CALC.
//   - CALC: 1 cycle for single-cycle ops; WIDTH cycles for mul/div.
//   - FIN: DONE=1 and RESULT/flags update; next cycle IDLE.
//   - START outside IDLE is ignored (no queueing).
//   - Latency START-sampled edge -> DONE high: 2 cycles single-cycle, WIDTH+1 mul/div.
//  Arith (mode 0), two's complement:
//   - 00 add, 01 sub (X + ~Y + 1).
//   - Add/sub RESULT = WIDTH+1-bit result sign-extended to 2*WIDTH.
//   - Add/sub OVERFLOW = signed overflow of the WIDTH-bit result.
//   - 10 unsigned multiply: RESULT = X*Y, shift-add, one partial product per cycle.
//   - 11 unsigned restoring divide: RESULT = {remainder, quotient}, one bit per cycle.
//   - Y==0: DIV_ZERO=1, RESULT all ones, CALC takes 1 cycle.
//  Logical (mode 1): 00 AND, 01 OR, 10 XOR, 11 NOT X; zero-extended, flags 0.
//  Compare (mode 2), unsigned; result in RESULT[0], rest 0:
//   - 00 X==Y, 01 X>Y, 10 X<Y.
//   - 11 max(X,Y) in RESULT[WIDTH-1:0].
//  Mode 3: RESULT=0, flags 0, single-cycle.
//  Flags clear at every DONE except the flag the current op sets.
//  RST_N low mid-operation aborts immediately; no DONE is produced for that op.
// STRUCTURE
//  Package calc_pkg:
//   - MODE_ARITH/LOGIC/CMP/RSVD localparams.
//   - OP_* codes.
//   - FSM state encodings IDLE/CALC/FIN.
//  Sub-module key_debounce (sync + stable counter + falling-edge pulse), parameter DEBOUNCE_CYCLES.
//  Mul/div share one WIDTH-bit iteration counter and one 2*WIDTH accumulator.
// TESTING (WIDTH=4, DEBOUNCE_CYCLES=8 for sim)
//  1 Reset held then released -> MODE=0, RESULT=8'h00, BUSY=0, DONE=0, flags 0.
//  2 Add: mode 0, op 00, X=7, Y=1, START -> DONE 2 cycles later, RESULT=8'h08, OVERFLOW=1.
//    Sub: X=3, Y=5 -> RESULT=8'hFE, OVERFLOW=0.
//  3 Multiply: op 10, X=15, Y=15 -> BUSY 4 cycles, DONE at cycle 5, RESULT=8'hE1.
//  4 Divide: op 11, X=13, Y=4 -> RESULT=8'h13.
//    X=5, Y=0 -> DIV_ZERO=1, RESULT=8'hFF, DONE at cycle 2.
//  5 Mode key: KEY_MODE bounces 0/1 every 3 cycles for 30 cycles -> MODE unchanged.
//    Held low 12 cycles -> MODE=1. Four clean presses -> MODE wraps back to 1.
//    Mode 2, op 01, X=9, Y=3 -> RESULT=8'h01.
//  6 START pulsed during multiply BUSY -> ignored, single DONE with original result.
//    RST_N low at CALC cycle 2 -> RESULT=0, no DONE, next START works normally.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared encodings for the sequential calculator core: modes, per-mode
// operation codes, FSM states and the multi-cycle operation classifier.
package calc_pkg;

  localparam logic [1:0] MODE_ARITH = 2'd0;
  localparam logic [1:0] MODE_LOGIC = 2'd1;
  localparam logic [1:0] MODE_CMP   = 2'd2;
  localparam logic [1:0] MODE_RSVD  = 2'd3;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_XOR = 2'b10;
  localparam logic [1:0] OP_NOT = 2'b11;

  localparam logic [1:0] OP_EQ  = 2'b00;
  localparam logic [1:0] OP_GT  = 2'b01;
  localparam logic [1:0] OP_LT  = 2'b10;
  localparam logic [1:0] OP_MAX = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIN  = 2'd2
  } state_e;

  // Multiply and non-zero divide iterate one bit per cycle; everything else is single-cycle.
  function automatic logic is_iter(input logic [1:0] mode, input logic [1:0] op,
                                   input logic y_zero);
    return (mode == MODE_ARITH) && ((op == OP_MUL) || ((op == OP_DIV) && !y_zero));
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Active-low push-button conditioner: two-flop synchroniser, stability
// counter, and a one-cycle pulse on each accepted press (1 -> 0).
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic press
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic [1:0]       sync_q, sync_d;
  logic             level_q, level_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             press_q, press_d;

  always_comb begin
    // NOTE: every output of this block gets a default first so no path can infer a latch.
    sync_d  = {sync_q[0], key_n};
    level_d = level_q;
    cnt_d   = '0;
    press_d = 1'b0;
    if (sync_q[1] != level_q) begin
      if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        level_d = sync_q[1];
        press_d = ~sync_q[1];
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // Released (high) is the idle level, so the chain resets to 1 to avoid a phantom press.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) begin
      sync_q  <= 2'b11;
      level_q <= 1'b1;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      level_q <= level_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
    end
  end

  assign press = press_q;

endmodule

// File: rtl/calc_engine.sv
// Sequential calculator core: debounced mode stepping plus an IDLE/CALC/FIN
// FSM running single-cycle ops and shift-add multiply / restoring divide.
module calc_engine
  import calc_pkg::*;
#(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic               KEY_MODE,
  input  logic [WIDTH-1:0]   X,
  input  logic [WIDTH-1:0]   Y,
  input  logic [1:0]         OPERATION,
  input  logic               START,
  output logic [1:0]         MODE,
  output logic               BUSY,
  output logic               DONE,
  output logic [2*WIDTH-1:0] RESULT,
  output logic               OVERFLOW,
  output logic               DIV_ZERO
);

  localparam int W  = WIDTH;
  localparam int RW = 2 * WIDTH;

  logic          key_press;
  state_e        state_q, state_d;
  logic [1:0]    mode_q, mode_d;
  logic [1:0]    mode_lat_q, mode_lat_d;
  logic [1:0]    op_q, op_d;
  logic [W-1:0]  x_q, x_d, y_q, y_d;
  logic [W-1:0]  cnt_q, cnt_d;
  logic [RW-1:0] acc_q, acc_d;
  logic [RW-1:0] result_q, result_d;
  logic          busy_q, busy_d, done_q, done_d, ovf_q, ovf_d, dz_q, dz_d;

  logic [W:0]    xe, ye, sum_ext, dif_ext;
  logic [RW-1:0] single_res;
  logic          single_ovf, single_dz, iter_op;
  logic [W:0]    mul_sum, div_t, div_diff;

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key (
    .clk   (CLK),
    .rst_n (RST_N),
    .key_n (KEY_MODE),
    .press (key_press)
  );

  // Single-cycle results from the latched operands; still valid during FIN.
  always_comb begin
    xe         = {x_q[W-1], x_q};
    ye         = {y_q[W-1], y_q};
    sum_ext    = xe + ye;
    dif_ext    = xe + ~ye + (W+1)'(1);
    single_res = '0;
    single_ovf = 1'b0;
    single_dz  = 1'b0;
    case (mode_lat_q)
      MODE_ARITH: begin
        case (op_q)
          OP_ADD: begin
            single_res = {{(W-1){sum_ext[W]}}, sum_ext};
            single_ovf = sum_ext[W] ^ sum_ext[W-1];
          end
          OP_SUB: begin
            single_res = {{(W-1){dif_ext[W]}}, dif_ext};
            single_ovf = dif_ext[W] ^ dif_ext[W-1];
          end
          OP_DIV: begin
            single_dz  = (y_q == '0);
            single_res = '1;
          end
          default: single_res = '0;
        endcase
      end
      MODE_LOGIC: begin
        case (op_q)
          OP_AND:  single_res = {{W{1'b0}}, x_q & y_q};
          OP_OR:   single_res = {{W{1'b0}}, x_q | y_q};
          OP_XOR:  single_res = {{W{1'b0}}, x_q ^ y_q};
          default: single_res = {{W{1'b0}}, ~x_q};
        endcase
      end
      MODE_CMP: begin
        case (op_q)
          OP_EQ:   single_res = {{(RW-1){1'b0}}, x_q == y_q};
          OP_GT:   single_res = {{(RW-1){1'b0}}, x_q > y_q};
          OP_LT:   single_res = {{(RW-1){1'b0}}, x_q < y_q};
          default: single_res = {{W{1'b0}}, (x_q > y_q) ? x_q : y_q};
        endcase
      end
      MODE_RSVD: single_res = '0;
      default:   single_res = '0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    mode_d     = key_press ? mode_q + 2'd1 : mode_q;
    mode_lat_d = mode_lat_q;
    op_d       = op_q;
    x_d        = x_q;
    y_d        = y_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    result_d   = result_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    ovf_d      = ovf_q;
    dz_d       = dz_q;

    iter_op  = is_iter(mode_lat_q, op_q, y_q == '0);
    mul_sum  = {1'b0, acc_q[RW-1:W]} + (acc_q[0] ? {1'b0, x_q} : '0);
    div_t    = {acc_q[RW-1:W], acc_q[W-1]};
    div_diff = div_t - {1'b0, y_q};

    case (state_q)
      IDLE: begin
        if (START) begin
          x_d        = X;
          y_d        = Y;
          mode_lat_d = mode_q;
          op_d       = OPERATION;
          cnt_d      = '0;
          // Multiply shifts Y out of the low half; divide shifts X in as the dividend.
          acc_d      = (OPERATION == OP_DIV) ? {{W{1'b0}}, X} : {{W{1'b0}}, Y};
          busy_d     = 1'b1;
          state_d    = CALC;
        end
      end
      CALC: begin
        if (iter_op) begin
          if (op_q == OP_MUL) begin
            acc_d = {mul_sum, acc_q[W-1:1]};
          end else if (div_t >= {1'b0, y_q}) begin
            acc_d = {div_diff[W-1:0], acc_q[W-2:0], 1'b1};
          end else begin
            acc_d = {div_t[W-1:0], acc_q[W-2:0], 1'b0};
          end
          if (cnt_q == W'(W - 1)) begin
            busy_d  = 1'b0;
            state_d = FIN;
          end else begin
            cnt_d = cnt_q + W'(1);
          end
        end else begin
          busy_d  = 1'b0;
          state_d = FIN;
        end
      end
      FIN: begin
        result_d = iter_op ? acc_q : single_res;
        ovf_d    = single_ovf;
        dz_d     = single_dz;
        done_d   = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= IDLE;
      mode_q     <= MODE_ARITH;
      mode_lat_q <= MODE_ARITH;
      op_q       <= '0;
      x_q        <= '0;
      y_q        <= '0;
      cnt_q      <= '0;
      acc_q      <= '0;
      result_q   <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ovf_q      <= 1'b0;
      dz_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      mode_lat_q <= mode_lat_d;
      op_q       <= op_d;
      x_q        <= x_d;
      y_q        <= y_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      result_q   <= result_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      ovf_q      <= ovf_d;
      dz_q       <= dz_d;
    end
  end

  assign MODE     = mode_q;
  assign BUSY     = busy_q;
  assign DONE     = done_q;
  assign RESULT   = result_q;
  assign OVERFLOW = ovf_q;
  assign DIV_ZERO = dz_q;

endmodule

// File: tb/tb_calc_engine.sv
// Self-checking bench for calc_engine: directed vector table, key debounce
// sequences, randomized ops against an arithmetic reference model, abort cases.
module tb_calc_engine;

  localparam int W  = 4;
  localparam int DB = 8;
  localparam int RW = 2 * W;

  logic          CLK = 1'b0;
  logic          RST_N, KEY_MODE, START;
  logic [W-1:0]  X, Y;
  logic [1:0]    OPERATION, MODE;
  logic          BUSY, DONE, OVERFLOW, DIV_ZERO;
  logic [RW-1:0] RESULT;

  int checks = 0;
  int errors = 0;
  int model_mode = 0;

  typedef struct {
    string         name;
    logic [1:0]    mode;
    logic [1:0]    op;
    logic [W-1:0]  x;
    logic [W-1:0]  y;
    logic [RW-1:0] res;
    logic          ovf;
    logic          dz;
    int            lat;
  } vec_t;

  vec_t vecs[$];

  calc_engine #(.WIDTH(W), .DEBOUNCE_CYCLES(DB)) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .KEY_MODE  (KEY_MODE),
    .X         (X),
    .Y         (Y),
    .OPERATION (OPERATION),
    .START     (START),
    .MODE      (MODE),
    .BUSY      (BUSY),
    .DONE      (DONE),
    .RESULT    (RESULT),
    .OVERFLOW  (OVERFLOW),
    .DIV_ZERO  (DIV_ZERO)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input string name, input int m, input int op, input int x,
                              input int y, input int res, input int ovf, input int dz,
                              input int lat);
    vec_t v;
    v.name = name;
    v.mode = 2'(m);
    v.op   = 2'(op);
    v.x    = W'(x);
    v.y    = W'(y);
    v.res  = RW'(res);
    v.ovf  = ovf[0];
    v.dz   = dz[0];
    v.lat  = lat;
    return v;
  endfunction

  // Reference model from plain integer arithmetic on the operand values.
  function automatic void model(input int m, input int op, input int x, input int y,
                                output logic [RW-1:0] r, output logic ovf,
                                output logic dz, output int lat);
    int half, full, xs, ys, s;
    half = 1 << (W - 1);
    full = 1 << W;
    xs   = (x >= half) ? x - full : x;
    ys   = (y >= half) ? y - full : y;
    r    = '0;
    ovf  = 1'b0;
    dz   = 1'b0;
    lat  = 2;
    s    = 0;
    if (m == 0) begin
      if (op == 0 || op == 1) begin
        s   = (op == 0) ? xs + ys : xs - ys;
        r   = RW'(s);
        ovf = (s >= half) || (s < -half);
      end else if (op == 2) begin
        r   = RW'(x * y);
        lat = W + 1;
      end else if (y == 0) begin
        r  = '1;
        dz = 1'b1;
      end else begin
        r   = RW'((x % y) * full + x / y);
        lat = W + 1;
      end
    end else if (m == 1) begin
      case (op)
        0:       r = RW'(x & y);
        1:       r = RW'(x | y);
        2:       r = RW'(x ^ y);
        default: r = RW'(full - 1 - x);
      endcase
    end else if (m == 2) begin
      case (op)
        0:       r = (x == y) ? RW'(1) : RW'(0);
        1:       r = (x > y) ? RW'(1) : RW'(0);
        2:       r = (x < y) ? RW'(1) : RW'(0);
        default: r = RW'((x > y) ? x : y);
      endcase
    end
  endfunction

  task automatic run_and_check(input string name, input logic [1:0] op, input logic [W-1:0] x,
                               input logic [W-1:0] y, input logic [RW-1:0] exp_res,
                               input logic exp_ovf, input logic exp_dz, input int exp_lat);
    int lat, busy_cnt;
    logic seen;
    @(negedge CLK);
    X = x;
    Y = y;
    OPERATION = op;
    START = 1'b1;
    @(posedge CLK);
    #1;
    START = 1'b0;
    busy_cnt = BUSY ? 1 : 0;
    lat = 0;
    seen = 1'b0;
    while (!seen && lat < 40) begin
      @(posedge CLK);
      #1;
      lat++;
      if (DONE) seen = 1'b1;
      else if (BUSY) busy_cnt++;
    end
    check({name, "_lat"}, lat, exp_lat);
    check({name, "_busy"}, busy_cnt, exp_lat - 1);
    check({name, "_res"}, 32'(RESULT), 32'(exp_res));
    check({name, "_ovf"}, 32'(OVERFLOW), 32'(exp_ovf));
    check({name, "_dz"}, 32'(DIV_ZERO), 32'(exp_dz));
    @(posedge CLK);
    #1;
    check({name, "_pulse"}, 32'(DONE), 0);
    check({name, "_hold"}, 32'(RESULT), 32'(exp_res));
  endtask

  task automatic press();
    @(negedge CLK);
    KEY_MODE = 1'b0;
    repeat (12) @(negedge CLK);
    KEY_MODE = 1'b1;
    repeat (12) @(negedge CLK);
    model_mode = (model_mode + 1) % 4;
  endtask

  task automatic set_mode(input int target);
    for (int k = 0; k < 4 && model_mode != target; k++) press();
    check("set_mode", 32'(MODE), target);
  endtask

  initial begin
    logic [RW-1:0] r;
    logic ovf, dz;
    int lat, done_cnt, done_at;
    logic [1:0] rop;
    logic [W-1:0] rx, ry;

    vecs.push_back(mk("add_7_1",   0, 0,  7,  1, 8'h08, 1, 0, 2));
    vecs.push_back(mk("sub_3_5",   0, 1,  3,  5, 8'hFE, 0, 0, 2));
    vecs.push_back(mk("add_neg",   0, 0,  8, 15, 8'hF7, 1, 0, 2));
    vecs.push_back(mk("sub_neg",   0, 1,  8,  1, 8'hF7, 1, 0, 2));
    vecs.push_back(mk("mul_15_15", 0, 2, 15, 15, 8'hE1, 0, 0, 5));
    vecs.push_back(mk("mul_0_9",   0, 2,  0,  9, 8'h00, 0, 0, 5));
    vecs.push_back(mk("div_13_4",  0, 3, 13,  4, 8'h13, 0, 0, 5));
    vecs.push_back(mk("div_5_0",   0, 3,  5,  0, 8'hFF, 0, 1, 2));
    vecs.push_back(mk("div_15_1",  0, 3, 15,  1, 8'h0F, 0, 0, 5));
    vecs.push_back(mk("div_7_9",   0, 3,  7,  9, 8'h70, 0, 0, 5));
    vecs.push_back(mk("and",       1, 0, 12, 10, 8'h08, 0, 0, 2));
    vecs.push_back(mk("or",        1, 1, 12, 10, 8'h0E, 0, 0, 2));
    vecs.push_back(mk("xor",       1, 2, 12, 10, 8'h06, 0, 0, 2));
    vecs.push_back(mk("not",       1, 3,  5, 10, 8'h0A, 0, 0, 2));
    vecs.push_back(mk("eq",        2, 0,  6,  6, 8'h01, 0, 0, 2));
    vecs.push_back(mk("gt_9_3",    2, 1,  9,  3, 8'h01, 0, 0, 2));
    vecs.push_back(mk("lt_9_3",    2, 2,  9,  3, 8'h00, 0, 0, 2));
    vecs.push_back(mk("max_3_9",   2, 3,  3,  9, 8'h09, 0, 0, 2));
    vecs.push_back(mk("rsvd",      3, 0, 15, 15, 8'h00, 0, 0, 2));

    RST_N = 1'b0;
    KEY_MODE = 1'b1;
    START = 1'b0;
    X = '0;
    Y = '0;
    OPERATION = '0;
    repeat (4) @(negedge CLK);
    RST_N = 1'b1;
    repeat (2) @(negedge CLK);
    check("rst_mode", 32'(MODE), 0);
    check("rst_result", 32'(RESULT), 0);
    check("rst_busy", 32'(BUSY), 0);
    check("rst_done", 32'(DONE), 0);
    check("rst_ovf", 32'(OVERFLOW), 0);
    check("rst_dz", 32'(DIV_ZERO), 0);

    for (int i = 0; i < 10; i++) begin
      KEY_MODE = (i % 2 == 0) ? 1'b0 : 1'b1;
      repeat (3) @(negedge CLK);
    end
    KEY_MODE = 1'b1;
    repeat (12) @(negedge CLK);
    check("bounce_mode", 32'(MODE), 0);
    press();
    check("hold_low_mode", 32'(MODE), 1);
    for (int i = 0; i < 4; i++) begin
      press();
      check("press_wrap", 32'(MODE), model_mode);
    end
    check("wrap_to_1", 32'(MODE), 1);

    foreach (vecs[i]) begin
      set_mode(int'(vecs[i].mode));
      run_and_check(vecs[i].name, vecs[i].op, vecs[i].x, vecs[i].y,
                    vecs[i].res, vecs[i].ovf, vecs[i].dz, vecs[i].lat);
    end

    for (int m = 0; m < 4; m++) begin
      set_mode(m);
      for (int n = 0; n < 12; n++) begin
        rop = 2'($urandom_range(0, 3));
        rx  = W'($urandom_range(0, (1 << W) - 1));
        ry  = W'($urandom_range(0, (1 << W) - 1));
        model(m, int'(rop), int'(rx), int'(ry), r, ovf, dz, lat);
        run_and_check("rand", rop, rx, ry, r, ovf, dz, lat);
      end
    end

    // START while a multiply is busy must be dropped.
    set_mode(0);
    @(negedge CLK);
    X = 4'd15;
    Y = 4'd15;
    OPERATION = 2'b10;
    START = 1'b1;
    @(posedge CLK);
    #1;
    START = 1'b0;
    done_cnt = 0;
    done_at = 0;
    for (int c = 1; c <= 12; c++) begin
      if (c == 2) begin
        X = 4'd1;
        Y = 4'd1;
        OPERATION = 2'b00;
        START = 1'b1;
      end else begin
        START = 1'b0;
      end
      @(posedge CLK);
      #1;
      if (DONE) begin
        done_cnt++;
        if (done_at == 0) done_at = c;
        check("busy_start_res", 32'(RESULT), 32'hE1);
      end
    end
    START = 1'b0;
    check("busy_start_dones", done_cnt, 1);
    check("busy_start_lat", done_at, 5);

    // Reset during the second CALC cycle aborts the multiply.
    @(negedge CLK);
    X = 4'd15;
    Y = 4'd15;
    OPERATION = 2'b10;
    START = 1'b1;
    @(posedge CLK);
    #1;
    START = 1'b0;
    @(posedge CLK);
    #1;
    RST_N = 1'b0;
    model_mode = 0;
    #1;
    check("abort_result", 32'(RESULT), 0);
    check("abort_busy", 32'(BUSY), 0);
    check("abort_mode", 32'(MODE), 0);
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;
    done_cnt = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge CLK);
      #1;
      if (DONE) done_cnt++;
    end
    check("abort_no_done", done_cnt, 0);
    run_and_check("after_abort", 2'b00, 4'd2, 4'd3, 8'h05, 1'b0, 1'b0, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
